// File: rtl/fila_pkg.sv
// -----------------------------------------------------------------------------
// fila_pkg
// Shared definitions for the queue front-end controller (fila_ctrl) and its
// button debouncer (debounce_pulse).
//   DATA_W     : width of the write data path to the queue
//   DEPTH      : default queue capacity used for the full check
//   LEN_W      : width of the queue length fed back from the queue
//   ERR_FULL   : err_out bit index for "push attempted while full"
//   ERR_EMPTY  : err_out bit index for "pop attempted while empty"
//   btn_state_t: per-button debounce FSM states
// -----------------------------------------------------------------------------
package fila_pkg;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int LEN_W  = 8;

    localparam int ERR_FULL  = 0;
    localparam int ERR_EMPTY = 1;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        FIRE,
        HELD,
        REL_DB
    } btn_state_t;

endpackage

// File: rtl/fila_ctrl_debounce_pulse.sv
// -----------------------------------------------------------------------------
// debounce_pulse
// Turns one raw, bouncy, asynchronous push-button into a clean single-cycle
// fire pulse. The button goes through a 2-FF synchroniser, then a debounce FSM
// that requires DEBOUNCE_CYCLES+1 consecutive equal samples to accept a press
// or a release.
//
// Optional build macro FILA_CTRL_REPEAT_EN: while the button stays in HELD,
// a repeat counter re-enters FIRE every REPEAT_CYCLES cycles. Without the
// macro there is exactly one pulse per press and no repeat counter.
//
// Ports:
//   clk_10KHz : clock
//   reset     : asynchronous, active-high reset
//   btn       : raw button input (asynchronous, bouncy)
//   fire      : registered one-cycle pulse, high while the FSM is in FIRE
// -----------------------------------------------------------------------------
module debounce_pulse
    import fila_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100,
    parameter int REPEAT_CYCLES   = 5000
) (
    input  logic clk_10KHz,
    input  logic reset,
    input  logic btn,
    output logic fire
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 2) begin : g_bad_params
        $error("debounce_pulse: need DEBOUNCE_CYCLES >= 1 and REPEAT_CYCLES >= 2");
    end

    logic             sync_a;
    logic             sync_b;
    btn_state_t       state;
    logic [CNT_W-1:0] count;

`ifdef FILA_CTRL_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(REPEAT_CYCLES - 1);

    // Counts cycles since the last FIRE (FIRE itself counts as cycle 0), so
    // consecutive pulses are exactly REPEAT_CYCLES apart.
    logic [RPT_W-1:0] rpt_count;
`endif

    always_ff @(posedge clk_10KHz or posedge reset) begin
        if (reset) begin
            sync_a    <= 1'b0;
            sync_b    <= 1'b0;
            state     <= IDLE;
            count     <= '0;
            fire      <= 1'b0;
`ifdef FILA_CTRL_REPEAT_EN
            rpt_count <= '0;
`endif
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
            fire   <= 1'b0;

            case (state)
                IDLE: begin
                    if (sync_b) begin
                        state <= PRESS_DB;
                        count <= CNT_W'(1);
                    end
                end

                // The press is accepted on the sample after the counter has
                // reached DEBOUNCE_CYCLES, i.e. DEBOUNCE_CYCLES+1 high samples.
                PRESS_DB: begin
                    if (!sync_b) begin
                        state <= IDLE;
                        count <= '0;
                    end else if (count == CNT_MAX) begin
                        state <= FIRE;
                        fire  <= 1'b1;
                        count <= '0;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end

                FIRE: begin
                    state     <= HELD;
`ifdef FILA_CTRL_REPEAT_EN
                    rpt_count <= RPT_W'(1);
`endif
                end

                HELD: begin
                    if (!sync_b) begin
                        state     <= REL_DB;
                        count     <= CNT_W'(1);
`ifdef FILA_CTRL_REPEAT_EN
                        rpt_count <= '0;
                    end else if (rpt_count == RPT_MAX) begin
                        state     <= FIRE;
                        fire      <= 1'b1;
                        rpt_count <= '0;
                    end else begin
                        rpt_count <= rpt_count + RPT_W'(1);
`endif
                    end
                end

                // Mirror of PRESS_DB: DEBOUNCE_CYCLES+1 low samples release.
                REL_DB: begin
                    if (sync_b) begin
                        state <= HELD;
                        count <= '0;
                    end else if (count == CNT_MAX) begin
                        state <= IDLE;
                        count <= '0;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/fila_ctrl.sv
// -----------------------------------------------------------------------------
// fila_ctrl
// Front-end controller for the 8-entry queue. Debounces the enqueue and
// dequeue buttons, turns each accepted press into one single-cycle command,
// and gates commands against the queue length fed back from the queue.
// Illegal attempts (push while full, pop while empty) pulse an error bit
// instead of issuing a command.
//
// Optional build macro FILA_CTRL_REPEAT_EN enables auto-repeat while a
// button is held (one command per REPEAT_CYCLES cycles).
//
// Ports:
//   clk_10KHz   : clock
//   reset       : asynchronous, active-high reset
//   btn_enq     : raw enqueue button
//   btn_deq     : raw dequeue button
//   sw_data     : raw data switches
//   len_in      : current queue length (unsigned)
//   enqueue_out : one-cycle enqueue command
//   dequeue_out : one-cycle dequeue command
//   data_out    : write data, valid with enqueue_out, held otherwise
//   full_out    : len_in >= DEPTH (combinational)
//   empty_out   : len_in == 0 (combinational)
//   err_out     : [ERR_FULL] push while full, [ERR_EMPTY] pop while empty
// -----------------------------------------------------------------------------
module fila_ctrl #(
    parameter int DEBOUNCE_CYCLES = 100,
    parameter int DEPTH           = fila_pkg::DEPTH,
    parameter int REPEAT_CYCLES   = 5000
) (
    input  logic                        clk_10KHz,
    input  logic                        reset,
    input  logic                        btn_enq,
    input  logic                        btn_deq,
    input  logic [fila_pkg::DATA_W-1:0] sw_data,
    input  logic [fila_pkg::LEN_W-1:0]  len_in,
    output logic                        enqueue_out,
    output logic                        dequeue_out,
    output logic [fila_pkg::DATA_W-1:0] data_out,
    output logic                        full_out,
    output logic                        empty_out,
    output logic [1:0]                  err_out
);

    import fila_pkg::*;

    localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(DEPTH);

    logic              req_enq;
    logic              req_deq;
    logic              pending;
    logic              deq_any;
    logic [DATA_W-1:0] sw_reg;

    debounce_pulse #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_db_enq (
        .clk_10KHz(clk_10KHz),
        .reset    (reset),
        .btn      (btn_enq),
        .fire     (req_enq)
    );

    debounce_pulse #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_db_deq (
        .clk_10KHz(clk_10KHz),
        .reset    (reset),
        .btn      (btn_deq),
        .fire     (req_deq)
    );

    // len_in above DEPTH still counts as full.
    assign full_out  = (len_in >= DEPTH_LEN);
    assign empty_out = (len_in == '0);

    // A dequeue that lost arbitration last cycle is retried now.
    assign deq_any = req_deq | pending;

    // Issue stage: enqueue has priority; a colliding dequeue is parked in
    // 'pending' and re-checked against len_in on the following cycle, so the
    // two commands can never be high together.
    always_ff @(posedge clk_10KHz or posedge reset) begin
        if (reset) begin
            sw_reg      <= '0;
            data_out    <= '0;
            enqueue_out <= 1'b0;
            dequeue_out <= 1'b0;
            err_out     <= '0;
            pending     <= 1'b0;
        end else begin
            sw_reg      <= sw_data;
            enqueue_out <= 1'b0;
            dequeue_out <= 1'b0;
            err_out     <= '0;

            if (req_enq) begin
                pending <= deq_any;
                if (!full_out) begin
                    enqueue_out <= 1'b1;
                    data_out    <= sw_reg;
                end else begin
                    err_out[ERR_FULL] <= 1'b1;
                end
            end else begin
                pending <= 1'b0;
                if (deq_any) begin
                    if (!empty_out) begin
                        dequeue_out <= 1'b1;
                    end else begin
                        err_out[ERR_EMPTY] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
